// File: rtl/mmio_hal_pkg.sv
// ----------------------------------------------------------------------------
// mmio_hal_pkg
// Shared types and constants for the MMIO host-side adapter.
//   mmio_len_t      : CCI-P MMIO access length encoding
//   TID_WIDTH       : width of the CCI-P read transaction ID
//   CCIP_ADDR_WIDTH : width of the CCI-P MMIO address (4-byte units)
//   RD_LATENCY      : cycles from read request to read response
//   isWordInRange   : inclusive window test on an 8-byte word address
// ----------------------------------------------------------------------------
package mmio_hal_pkg;

    typedef enum logic [1:0] {
        LEN_4B  = 2'd0,
        LEN_8B  = 2'd1,
        LEN_64B = 2'd2
    } mmio_len_t;

    localparam int TID_WIDTH       = 9;
    localparam int CCIP_ADDR_WIDTH = 16;
    localparam int RD_LATENCY      = 3;

    // Signed compare so a window starting at word 0 does not turn into a
    // constant unsigned comparison against zero.
    function automatic logic isWordInRange(input logic [31:0] wordAddr,
                                           input int          lo,
                                           input int          hi);
        return ($signed(wordAddr) >= lo) && ($signed(wordAddr) <= hi);
    endfunction

endpackage

// File: rtl/mmio_hal_rsp_pipe.sv
// ----------------------------------------------------------------------------
// mmio_hal_rsp_pipe
// Delay line that carries a read's valid bit, transaction ID and in-range
// flag from request capture to the response cycle (RD_LATENCY stages).
// Only the valid bits are reset; tid/inRange are qualified by valid.
//   clk, rst    : clock, asynchronous active-high reset
//   i_valid     : read accepted this cycle
//   i_tid       : its transaction ID
//   i_inRange   : read was forwarded to the user block
//   o_valid     : response cycle for the oldest read
//   o_tid       : transaction ID to echo
//   o_inRange   : response carries user data (else zero)
// ----------------------------------------------------------------------------
module mmio_hal_rsp_pipe
    import mmio_hal_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [TID_WIDTH-1:0] i_tid,
    input  logic                 i_inRange,
    output logic                 o_valid,
    output logic [TID_WIDTH-1:0] o_tid,
    output logic                 o_inRange
);

    logic [RD_LATENCY-1:0] r_valid;
    logic [RD_LATENCY-1:0] r_inRange;
    logic [TID_WIDTH-1:0]  r_tid [RD_LATENCY];

    // Valid bits shift one stage per cycle; reset drops every in-flight read
    // so no response is ever produced for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= {r_valid[RD_LATENCY-2:0], i_valid};
        end
    end

    // Payload travels alongside the valid bits; it is only looked at when the
    // matching valid bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        r_inRange <= {r_inRange[RD_LATENCY-2:0], i_inRange};
        r_tid[0]  <= i_tid;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_tid[i] <= r_tid[i-1];
        end
    end

    assign o_valid   = r_valid[RD_LATENCY-1];
    assign o_tid     = r_tid[RD_LATENCY-1];
    assign o_inRange = r_inRange[RD_LATENCY-1];

endmodule

// File: rtl/mmio_hal.sv
// ----------------------------------------------------------------------------
// mmio_hal
// Host-side end of the mmio_if abstraction. Turns CCI-P MMIO request headers
// into one-cycle mmio_if read/write strobes, samples the user's read data one
// cycle later and returns a CCI-P read response carrying the original
// transaction ID, exactly 3 cycles after every read request.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_rd_valid/req_wr_valid : CCI-P MMIO read / write request
//   req_addr                  : CCI-P address in 4-byte units
//   req_length                : 0=4B, 1=8B, 2=64B (only 8B is forwarded)
//   req_tid, req_data         : read transaction ID, write data
//   rsp_valid/rsp_tid/rsp_data: read response towards CCI-P c2
//   mmio_rd_en/mmio_rd_addr   : mmio_if read strobe and word address
//   mmio_rd_data              : mmio_if read data, valid cycle after rd_en
//   mmio_wr_en/mmio_wr_addr/mmio_wr_data : mmio_if write strobe
//   err_proto                 : sticky, dual rd+wr or non-8B access seen
// ----------------------------------------------------------------------------
module mmio_hal
    import mmio_hal_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 'hFFF
)
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_rd_valid,
    input  logic                       req_wr_valid,
    input  logic [CCIP_ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]                 req_length,
    input  logic [TID_WIDTH-1:0]       req_tid,
    input  logic [DATA_WIDTH-1:0]      req_data,
    output logic                       rsp_valid,
    output logic [TID_WIDTH-1:0]       rsp_tid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       mmio_rd_en,
    output logic [ADDR_WIDTH-1:0]      mmio_rd_addr,
    input  logic [DATA_WIDTH-1:0]      mmio_rd_data,
    output logic                       mmio_wr_en,
    output logic [ADDR_WIDTH-1:0]      mmio_wr_addr,
    output logic [DATA_WIDTH-1:0]      mmio_wr_data,
    output logic                       err_proto
);

    logic [31:0]           w_wordAddr;
    logic                  w_len8B;
    logic                  w_inRange;
    logic                  w_rdOnly;
    logic                  w_protoErr;
    logic                  w_pipeValid;
    logic                  w_pipeInRange;
    logic [TID_WIDTH-1:0]  w_pipeTid;

    logic                  r_rdEn;
    logic                  r_wrEn;
    logic [ADDR_WIDTH-1:0] r_rdAddr;
    logic [ADDR_WIDTH-1:0] r_wrAddr;
    logic [DATA_WIDTH-1:0] r_wrData;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_errProto;

    // CCI-P addresses count 4-byte units; mmio_if counts 8-byte words.
    assign w_wordAddr = 32'(req_addr) >> 1;
    assign w_len8B    = (req_length == LEN_8B);
    assign w_inRange  = w_len8B && isWordInRange(w_wordAddr, START_ADDR, END_ADDR);

    // A read that arrives together with a write is discarded: the write wins.
    assign w_rdOnly   = req_rd_valid && !req_wr_valid;
    assign w_protoErr = (req_rd_valid && req_wr_valid) ||
                        ((req_rd_valid || req_wr_valid) && !w_len8B);

    // Request capture: strobes pulse for one cycle after the request, address
    // and data registers hold the last accepted access of each kind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdEn     <= 1'b0;
            r_wrEn     <= 1'b0;
            r_rdAddr   <= '0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_errProto <= 1'b0;
        end else begin
            r_rdEn     <= w_rdOnly && w_inRange;
            r_wrEn     <= req_wr_valid && w_inRange;
            r_errProto <= r_errProto || w_protoErr;
            if (w_rdOnly) begin
                r_rdAddr <= w_wordAddr[ADDR_WIDTH-1:0];
            end
            if (req_wr_valid) begin
                r_wrAddr <= w_wordAddr[ADDR_WIDTH-1:0];
                r_wrData <= req_data;
            end
        end
    end

    // User read data is sampled every cycle; the pipe's in-range flag decides
    // in the response cycle whether it is returned or replaced by zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdData <= '0;
        end else begin
            r_rdData <= mmio_rd_data;
        end
    end

    mmio_hal_rsp_pipe u_rspPipe (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_rdOnly),
        .i_tid     (req_tid),
        .i_inRange (w_inRange),
        .o_valid   (w_pipeValid),
        .o_tid     (w_pipeTid),
        .o_inRange (w_pipeInRange)
    );

    assign rsp_valid    = w_pipeValid;
    assign rsp_tid      = w_pipeValid ? w_pipeTid : '0;
    assign rsp_data     = (w_pipeValid && w_pipeInRange) ? r_rdData : '0;
    assign mmio_rd_en   = r_rdEn;
    assign mmio_rd_addr = r_rdAddr;
    assign mmio_wr_en   = r_wrEn;
    assign mmio_wr_addr = r_wrAddr;
    assign mmio_wr_data = r_wrData;
    assign err_proto    = r_errProto;

endmodule

// File: tb/tb_mmio_hal.sv
// ----------------------------------------------------------------------------
// tb_mmio_hal
// Directed bench for mmio_hal. A small user-side model answers mmio_if reads
// one cycle after rd_en; all expected values are written out by hand below.
// ----------------------------------------------------------------------------
module tb_mmio_hal;

    logic        clk;
    logic        rst;
    logic        req_rd_valid;
    logic        req_wr_valid;
    logic [15:0] req_addr;
    logic [1:0]  req_length;
    logic [8:0]  req_tid;
    logic [63:0] req_data;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic        mmio_rd_en;
    logic [15:0] mmio_rd_addr;
    logic [63:0] mmio_rd_data;
    logic        mmio_wr_en;
    logic [15:0] mmio_wr_addr;
    logic [63:0] mmio_wr_data;
    logic        err_proto;

    int assertCount = 0;
    int failCount   = 0;

    mmio_hal dut (
        .clk          (clk),
        .rst          (rst),
        .req_rd_valid (req_rd_valid),
        .req_wr_valid (req_wr_valid),
        .req_addr     (req_addr),
        .req_length   (req_length),
        .req_tid      (req_tid),
        .req_data     (req_data),
        .rsp_valid    (rsp_valid),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .mmio_rd_en   (mmio_rd_en),
        .mmio_rd_addr (mmio_rd_addr),
        .mmio_rd_data (mmio_rd_data),
        .mmio_wr_en   (mmio_wr_en),
        .mmio_wr_addr (mmio_wr_addr),
        .mmio_wr_data (mmio_wr_data),
        .err_proto    (err_proto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register contents the user block returns; word 0x10 holds a fixed
    // pattern, every other word returns a tag built from its address.
    function automatic logic [63:0] userData(input logic [15:0] addr);
        if (addr == 16'h0010) return 64'hDEAD_BEEF_0000_0001;
        return {32'hA5A5_0000, 16'h0000, addr};
    endfunction

    // User side of mmio_if: answers a read on the cycle after rd_en and
    // drives a recognisable junk value otherwise.
    always @(posedge clk) begin
        mmio_rd_data <= mmio_rd_en ? userData(mmio_rd_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic        rd,
                                 input logic        wr,
                                 input logic [15:0] addr,
                                 input logic [1:0]  len,
                                 input logic [8:0]  tid,
                                 input logic [63:0] data);
        req_rd_valid = rd;
        req_wr_valid = wr;
        req_addr     = addr;
        req_length   = len;
        req_tid      = tid;
        req_data     = data;
    endtask

    task automatic checkOutput(input string       tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0000, 2'd1, 9'h000, 64'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        stepCycle();
        stepCycle();

        $display("[TB] reset state");
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("rst_rsp_tid", 64'(rsp_tid), 64'h0);
        checkOutput("rst_rsp_data", rsp_data, 64'h0);
        checkOutput("rst_rd_en", 64'(mmio_rd_en), 64'h0);
        checkOutput("rst_wr_en", 64'(mmio_wr_en), 64'h0);
        checkOutput("rst_wr_addr", 64'(mmio_wr_addr), 64'h0);
        checkOutput("rst_wr_data", mmio_wr_data, 64'h0);
        checkOutput("rst_err", 64'(err_proto), 64'h0);
        rst = 1'b0;
        stepCycle();

        $display("[TB] single in-range read");
        applyStimulus(1'b1, 1'b0, 16'h0020, 2'd1, 9'h1A5, 64'h0);
        stepCycle();
        idle();
        checkOutput("rd1_rd_en_n1", 64'(mmio_rd_en), 64'h1);
        checkOutput("rd1_rd_addr_n1", 64'(mmio_rd_addr), 64'h0010);
        checkOutput("rd1_rsp_valid_n1", 64'(rsp_valid), 64'h0);
        stepCycle();
        checkOutput("rd1_rd_en_n2", 64'(mmio_rd_en), 64'h0);
        checkOutput("rd1_rsp_valid_n2", 64'(rsp_valid), 64'h0);
        stepCycle();
        checkOutput("rd1_rsp_valid_n3", 64'(rsp_valid), 64'h1);
        checkOutput("rd1_rsp_tid_n3", 64'(rsp_tid), 64'h1A5);
        checkOutput("rd1_rsp_data_n3", rsp_data, 64'hDEAD_BEEF_0000_0001);
        stepCycle();
        checkOutput("rd1_rsp_valid_n4", 64'(rsp_valid), 64'h0);

        $display("[TB] single in-range write");
        applyStimulus(1'b0, 1'b1, 16'h0040, 2'd1, 9'h000, 64'h0000_0000_0000_1234);
        stepCycle();
        idle();
        checkOutput("wr_wr_en_n1", 64'(mmio_wr_en), 64'h1);
        checkOutput("wr_wr_addr_n1", 64'(mmio_wr_addr), 64'h0020);
        checkOutput("wr_wr_data_n1", mmio_wr_data, 64'h1234);
        checkOutput("wr_rd_en_n1", 64'(mmio_rd_en), 64'h0);
        stepCycle();
        checkOutput("wr_wr_en_n2", 64'(mmio_wr_en), 64'h0);
        stepCycle();
        checkOutput("wr_rsp_valid_n3", 64'(rsp_valid), 64'h0);
        stepCycle();

        // Reads at cycles N..N+7 to words 0x80..0x87; response j lands at N+3+j.
        $display("[TB] eight back-to-back reads");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 2'd1, 9'(i), 64'h0);
            stepCycle();
            checkOutput($sformatf("b2b_rd_en_%0d", i), 64'(mmio_rd_en), 64'h1);
            checkOutput($sformatf("b2b_rd_addr_%0d", i), 64'(mmio_rd_addr), 64'(16'h0080 + i));
            if (i >= 2) begin
                checkOutput($sformatf("b2b_rsp_valid_%0d", i - 2), 64'(rsp_valid), 64'h1);
                checkOutput($sformatf("b2b_rsp_tid_%0d", i - 2), 64'(rsp_tid), 64'(i - 2));
                checkOutput($sformatf("b2b_rsp_data_%0d", i - 2), rsp_data,
                            64'hA5A5_0000_0000_0080 + 64'(i - 2));
            end
        end
        idle();
        for (int j = 6; j < 8; j++) begin
            stepCycle();
            checkOutput($sformatf("b2b_rsp_valid_%0d", j), 64'(rsp_valid), 64'h1);
            checkOutput($sformatf("b2b_rsp_tid_%0d", j), 64'(rsp_tid), 64'(j));
            checkOutput($sformatf("b2b_rsp_data_%0d", j), rsp_data, 64'hA5A5_0000_0000_0080 + 64'(j));
        end
        stepCycle();
        checkOutput("b2b_rsp_valid_after", 64'(rsp_valid), 64'h0);

        $display("[TB] last in-range word");
        applyStimulus(1'b1, 1'b0, 16'h1FFE, 2'd1, 9'h044, 64'h0);
        stepCycle();
        idle();
        checkOutput("end_rd_en", 64'(mmio_rd_en), 64'h1);
        checkOutput("end_rd_addr", 64'(mmio_rd_addr), 64'h0FFF);
        stepCycle();
        stepCycle();
        checkOutput("end_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("end_rsp_tid", 64'(rsp_tid), 64'h044);
        checkOutput("end_rsp_data", rsp_data, 64'hA5A5_0000_0000_0FFF);
        stepCycle();

        $display("[TB] first out-of-range word");
        applyStimulus(1'b1, 1'b0, 16'h2000, 2'd1, 9'h033, 64'h0);
        stepCycle();
        idle();
        checkOutput("oor_rd_en", 64'(mmio_rd_en), 64'h0);
        stepCycle();
        stepCycle();
        checkOutput("oor_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("oor_rsp_tid", 64'(rsp_tid), 64'h033);
        checkOutput("oor_rsp_data", rsp_data, 64'h0);
        checkOutput("oor_err", 64'(err_proto), 64'h0);
        stepCycle();

        $display("[TB] simultaneous read and write");
        applyStimulus(1'b1, 1'b1, 16'h0060, 2'd1, 9'h0AA, 64'h0000_0000_0000_5555);
        stepCycle();
        idle();
        checkOutput("dual_wr_en", 64'(mmio_wr_en), 64'h1);
        checkOutput("dual_wr_addr", 64'(mmio_wr_addr), 64'h0030);
        checkOutput("dual_wr_data", mmio_wr_data, 64'h5555);
        checkOutput("dual_rd_en", 64'(mmio_rd_en), 64'h0);
        checkOutput("dual_err", 64'(err_proto), 64'h1);
        stepCycle();
        stepCycle();
        checkOutput("dual_rsp_valid_n3", 64'(rsp_valid), 64'h0);
        stepCycle();

        $display("[TB] 4-byte read");
        applyStimulus(1'b1, 1'b0, 16'h0020, 2'd0, 9'h0BB, 64'h0);
        stepCycle();
        idle();
        checkOutput("len4_rd_en", 64'(mmio_rd_en), 64'h0);
        stepCycle();
        stepCycle();
        checkOutput("len4_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("len4_rsp_tid", 64'(rsp_tid), 64'h0BB);
        checkOutput("len4_rsp_data", rsp_data, 64'h0);
        stepCycle();
        checkOutput("len4_err_sticky", 64'(err_proto), 64'h1);

        // Two reads in flight, a third presented while reset rises.
        $display("[TB] reset with reads in flight");
        applyStimulus(1'b1, 1'b0, 16'h0020, 2'd1, 9'h001, 64'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0022, 2'd1, 9'h002, 64'h0);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 16'h0024, 2'd1, 9'h003, 64'h0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_rd_en", 64'(mmio_rd_en), 64'h0);
        checkOutput("mid_rst_rd_addr", 64'(mmio_rd_addr), 64'h0);
        checkOutput("mid_rst_err", 64'(err_proto), 64'h0);
        checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        stepCycle();
        rst = 1'b0;
        idle();
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            checkOutput($sformatf("post_rst_rsp_valid_%0d", k), 64'(rsp_valid), 64'h0);
            checkOutput($sformatf("post_rst_rd_en_%0d", k), 64'(mmio_rd_en), 64'h0);
        end
        checkOutput("post_rst_err", 64'(err_proto), 64'h0);
        checkOutput("post_rst_rsp_data", rsp_data, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
